// File: rtl/axi_read_arbiter.sv
// Two-port AXI3 read arbiter: data cache (s0) and instruction cache (s1) share one
// downstream read master, one transaction at a time, fixed or round-robin priority.
module axi_read_arbiter #(
  parameter bit RR_EN = 1'b1,
  localparam int unsigned ID_W    = 4,
  localparam int unsigned ADDR_W  = 32,
  localparam int unsigned LEN_W   = 4,
  localparam int unsigned SIZE_W  = 3,
  localparam int unsigned BURST_W = 2,
  localparam int unsigned LOCK_W  = 2,
  localparam int unsigned CACHE_W = 4,
  localparam int unsigned PROT_W  = 3,
  localparam int unsigned DATA_W  = 32,
  localparam int unsigned RESP_W  = 2
) (
  input  logic               aclk,
  input  logic               aresetn,
  // data cache
  input  logic [ID_W-1:0]    s0_arid,
  input  logic [ADDR_W-1:0]  s0_araddr,
  input  logic [LEN_W-1:0]   s0_arlen,
  input  logic [SIZE_W-1:0]  s0_arsize,
  input  logic [BURST_W-1:0] s0_arburst,
  input  logic [LOCK_W-1:0]  s0_arlock,
  input  logic [CACHE_W-1:0] s0_arcache,
  input  logic [PROT_W-1:0]  s0_arprot,
  input  logic               s0_arvalid,
  output logic               s0_arready,
  output logic [ID_W-1:0]    s0_rid,
  output logic [DATA_W-1:0]  s0_rdata,
  output logic [RESP_W-1:0]  s0_rresp,
  output logic               s0_rlast,
  output logic               s0_rvalid,
  input  logic               s0_rready,
  // instruction cache
  input  logic [ID_W-1:0]    s1_arid,
  input  logic [ADDR_W-1:0]  s1_araddr,
  input  logic [LEN_W-1:0]   s1_arlen,
  input  logic [SIZE_W-1:0]  s1_arsize,
  input  logic [BURST_W-1:0] s1_arburst,
  input  logic [LOCK_W-1:0]  s1_arlock,
  input  logic [CACHE_W-1:0] s1_arcache,
  input  logic [PROT_W-1:0]  s1_arprot,
  input  logic               s1_arvalid,
  output logic               s1_arready,
  output logic [ID_W-1:0]    s1_rid,
  output logic [DATA_W-1:0]  s1_rdata,
  output logic [RESP_W-1:0]  s1_rresp,
  output logic               s1_rlast,
  output logic               s1_rvalid,
  input  logic               s1_rready,
  // downstream master
  output logic [ID_W-1:0]    m_arid,
  output logic [ADDR_W-1:0]  m_araddr,
  output logic [LEN_W-1:0]   m_arlen,
  output logic [SIZE_W-1:0]  m_arsize,
  output logic [BURST_W-1:0] m_arburst,
  output logic [LOCK_W-1:0]  m_arlock,
  output logic [CACHE_W-1:0] m_arcache,
  output logic [PROT_W-1:0]  m_arprot,
  output logic               m_arvalid,
  input  logic               m_arready,
  input  logic [ID_W-1:0]    m_rid,
  input  logic [DATA_W-1:0]  m_rdata,
  input  logic [RESP_W-1:0]  m_rresp,
  input  logic               m_rlast,
  input  logic               m_rvalid,
  output logic               m_rready,
  output logic [1:0]         grant_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;   // 1: s1 was granted last
  logic       win_s1;

  // Arbitration and transaction sequencing
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    win_s1  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_arvalid || s1_arvalid) begin
          if (s0_arvalid && s1_arvalid) begin
            win_s1 = RR_EN ? ~last_q : 1'b0;
          end else begin
            win_s1 = s1_arvalid;
          end
          grant_d = win_s1 ? 2'b10 : 2'b01;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (m_arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (m_rvalid && m_rready && m_rlast) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = grant_q[1];
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Channel muxing selected only by registered state and grant
  always_comb begin
    m_arid     = '0;
    m_araddr   = '0;
    m_arlen    = '0;
    m_arsize   = '0;
    m_arburst  = '0;
    m_arlock   = '0;
    m_arcache  = '0;
    m_arprot   = '0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rid     = '0;
    s0_rdata   = '0;
    s0_rresp   = '0;
    s0_rlast   = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rid     = '0;
    s1_rdata   = '0;
    s1_rresp   = '0;
    s1_rlast   = 1'b0;
    s1_rvalid  = 1'b0;
    if (state_q == ADDR) begin
      m_arid     = grant_q[1] ? s1_arid    : s0_arid;
      m_araddr   = grant_q[1] ? s1_araddr  : s0_araddr;
      m_arlen    = grant_q[1] ? s1_arlen   : s0_arlen;
      m_arsize   = grant_q[1] ? s1_arsize  : s0_arsize;
      m_arburst  = grant_q[1] ? s1_arburst : s0_arburst;
      m_arlock   = grant_q[1] ? s1_arlock  : s0_arlock;
      m_arcache  = grant_q[1] ? s1_arcache : s0_arcache;
      m_arprot   = grant_q[1] ? s1_arprot  : s0_arprot;
      m_arvalid  = 1'b1;
      s0_arready = grant_q[0] & m_arready;
      s1_arready = grant_q[1] & m_arready;
    end
    if (state_q == DATA) begin
      m_rready = grant_q[1] ? s1_rready : s0_rready;
      if (grant_q[0]) begin
        s0_rid    = m_rid;
        s0_rdata  = m_rdata;
        s0_rresp  = m_rresp;
        s0_rlast  = m_rlast;
        s0_rvalid = m_rvalid;
      end
      if (grant_q[1]) begin
        s1_rid    = m_rid;
        s1_rdata  = m_rdata;
        s1_rresp  = m_rresp;
        s1_rlast  = m_rlast;
        s1_rvalid = m_rvalid;
      end
    end
  end

  assign grant_o = grant_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed per-cycle vectors for the AXI read arbiter; one round-robin and one
// fixed-priority instance share stimulus, each vector names the instance it checks.
module tb_axi_read_arbiter;

  logic aclk = 1'b0;
  logic aresetn;
  logic [3:0]  s0_arid, s1_arid, s0_arlen, s1_arlen, s0_arcache, s1_arcache;
  logic [31:0] s0_araddr, s1_araddr;
  logic [2:0]  s0_arsize, s1_arsize, s0_arprot, s1_arprot;
  logic [1:0]  s0_arburst, s1_arburst, s0_arlock, s1_arlock;
  logic        s0_arvalid, s1_arvalid, s0_rready, s1_rready;
  logic        m_arready, m_rlast, m_rvalid;
  logic [3:0]  m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;

  // round-robin instance outputs
  logic        r_s0_arready, r_s0_rlast, r_s0_rvalid, r_s1_arready, r_s1_rlast, r_s1_rvalid;
  logic [3:0]  r_s0_rid, r_s1_rid, r_m_arid, r_m_arlen, r_m_arcache;
  logic [31:0] r_s0_rdata, r_s1_rdata, r_m_araddr;
  logic [1:0]  r_s0_rresp, r_s1_rresp, r_m_arburst, r_m_arlock, r_grant;
  logic [2:0]  r_m_arsize, r_m_arprot;
  logic        r_m_arvalid, r_m_rready;
  // fixed-priority instance outputs
  logic        f_s0_arready, f_s0_rlast, f_s0_rvalid, f_s1_arready, f_s1_rlast, f_s1_rvalid;
  logic [3:0]  f_s0_rid, f_s1_rid, f_m_arid, f_m_arlen, f_m_arcache;
  logic [31:0] f_s0_rdata, f_s1_rdata, f_m_araddr;
  logic [1:0]  f_s0_rresp, f_s1_rresp, f_m_arburst, f_m_arlock, f_grant;
  logic [2:0]  f_m_arsize, f_m_arprot;
  logic        f_m_arvalid, f_m_rready;

  int n_checks = 0;
  int n_fail   = 0;
  int vec_idx  = 0;

  always #5 aclk = ~aclk;

  axi_read_arbiter #(.RR_EN(1'b1)) u_rr (
    .aclk(aclk), .aresetn(aresetn),
    .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arburst(s0_arburst), .s0_arlock(s0_arlock), .s0_arcache(s0_arcache), .s0_arprot(s0_arprot),
    .s0_arvalid(s0_arvalid), .s0_arready(r_s0_arready),
    .s0_rid(r_s0_rid), .s0_rdata(r_s0_rdata), .s0_rresp(r_s0_rresp), .s0_rlast(r_s0_rlast),
    .s0_rvalid(r_s0_rvalid), .s0_rready(s0_rready),
    .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
    .s1_arburst(s1_arburst), .s1_arlock(s1_arlock), .s1_arcache(s1_arcache), .s1_arprot(s1_arprot),
    .s1_arvalid(s1_arvalid), .s1_arready(r_s1_arready),
    .s1_rid(r_s1_rid), .s1_rdata(r_s1_rdata), .s1_rresp(r_s1_rresp), .s1_rlast(r_s1_rlast),
    .s1_rvalid(r_s1_rvalid), .s1_rready(s1_rready),
    .m_arid(r_m_arid), .m_araddr(r_m_araddr), .m_arlen(r_m_arlen), .m_arsize(r_m_arsize),
    .m_arburst(r_m_arburst), .m_arlock(r_m_arlock), .m_arcache(r_m_arcache), .m_arprot(r_m_arprot),
    .m_arvalid(r_m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(r_m_rready), .grant_o(r_grant)
  );

  axi_read_arbiter #(.RR_EN(1'b0)) u_fx (
    .aclk(aclk), .aresetn(aresetn),
    .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arburst(s0_arburst), .s0_arlock(s0_arlock), .s0_arcache(s0_arcache), .s0_arprot(s0_arprot),
    .s0_arvalid(s0_arvalid), .s0_arready(f_s0_arready),
    .s0_rid(f_s0_rid), .s0_rdata(f_s0_rdata), .s0_rresp(f_s0_rresp), .s0_rlast(f_s0_rlast),
    .s0_rvalid(f_s0_rvalid), .s0_rready(s0_rready),
    .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
    .s1_arburst(s1_arburst), .s1_arlock(s1_arlock), .s1_arcache(s1_arcache), .s1_arprot(s1_arprot),
    .s1_arvalid(s1_arvalid), .s1_arready(f_s1_arready),
    .s1_rid(f_s1_rid), .s1_rdata(f_s1_rdata), .s1_rresp(f_s1_rresp), .s1_rlast(f_s1_rlast),
    .s1_rvalid(f_s1_rvalid), .s1_rready(s1_rready),
    .m_arid(f_m_arid), .m_araddr(f_m_araddr), .m_arlen(f_m_arlen), .m_arsize(f_m_arsize),
    .m_arburst(f_m_arburst), .m_arlock(f_m_arlock), .m_arcache(f_m_arcache), .m_arprot(f_m_arprot),
    .m_arvalid(f_m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(f_m_rready), .grant_o(f_grant)
  );

  // in_b  = {s0_arvalid, s1_arvalid, m_arready, m_rvalid, m_rlast, s0_rready, s1_rready}
  // out_b = {m_arvalid, m_rready, s0_arready, s1_arready, s0_rvalid, s1_rvalid}
  typedef struct {
    logic        rst;
    logic        fx;
    logic [6:0]  in_b;
    logic [31:0] d;
    logic [1:0]  g;
    logic [5:0]  out_b;
  } vec_t;

  vec_t table_q[$];

  function automatic vec_t mk(input logic rst, input logic fx, input logic [6:0] in_b,
                              input logic [31:0] d, input logic [1:0] g, input logic [5:0] out_b);
    vec_t v;
    v.rst = rst; v.fx = fx; v.in_b = in_b; v.d = d; v.g = g; v.out_b = out_b;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    logic [7:0]  act_c;
    logic [42:0] act_a, exp_a;
    logic [38:0] act_r, exp_r;
    @(negedge aclk);
    aresetn = ~v.rst;
    {s0_arvalid, s1_arvalid, m_arready, m_rvalid, m_rlast, s0_rready, s1_rready} = v.in_b;
    m_rdata = v.d;
    #2;
    vec_idx++;
    act_c = v.fx ? {f_grant, f_m_arvalid, f_m_rready, f_s0_arready, f_s1_arready, f_s0_rvalid, f_s1_rvalid}
                 : {r_grant, r_m_arvalid, r_m_rready, r_s0_arready, r_s1_arready, r_s0_rvalid, r_s1_rvalid};
    act_a = v.fx ? {f_m_arid, f_m_araddr, f_m_arlen, f_m_arprot}
                 : {r_m_arid, r_m_araddr, r_m_arlen, r_m_arprot};
    n_checks++;
    if (act_c !== {v.g, v.out_b}) begin
      n_fail++;
      $display("FAIL vec%0d ctl {grant,arv,rrdy,ar0,ar1,rv0,rv1} got=%b want=%b", vec_idx, act_c, {v.g, v.out_b});
    end
    if (v.out_b[5]) begin
      exp_a = v.g[1] ? {s1_arid, s1_araddr, s1_arlen, s1_arprot} : {s0_arid, s0_araddr, s0_arlen, s0_arprot};
      n_checks++;
      if (act_a !== exp_a) begin
        n_fail++;
        $display("FAIL vec%0d ar_fields got=%h want=%h", vec_idx, act_a, exp_a);
      end
    end
    exp_r = {m_rid, v.d, m_rresp, v.in_b[2]};
    if (v.out_b[1]) begin
      act_r = v.fx ? {f_s0_rid, f_s0_rdata, f_s0_rresp, f_s0_rlast} : {r_s0_rid, r_s0_rdata, r_s0_rresp, r_s0_rlast};
      n_checks++;
      if (act_r !== exp_r) begin
        n_fail++;
        $display("FAIL vec%0d s0_r got=%h want=%h", vec_idx, act_r, exp_r);
      end
    end
    if (v.out_b[0]) begin
      act_r = v.fx ? {f_s1_rid, f_s1_rdata, f_s1_rresp, f_s1_rlast} : {r_s1_rid, r_s1_rdata, r_s1_rresp, r_s1_rlast};
      n_checks++;
      if (act_r !== exp_r) begin
        n_fail++;
        $display("FAIL vec%0d s1_r got=%h want=%h", vec_idx, act_r, exp_r);
      end
    end
    if (v.rst) begin
      n_checks++;
      if (act_a !== 43'd0) begin
        n_fail++;
        $display("FAIL vec%0d reset_ar_fields got=%h want=0", vec_idx, act_a);
      end
    end
  endtask

  initial begin
    aresetn = 1'b0;
    s0_arid = 4'h3; s0_araddr = 32'h1FC0_0000; s0_arlen = 4'd0; s0_arsize = 3'd2;
    s0_arburst = 2'b01; s0_arlock = 2'b00; s0_arcache = 4'h0; s0_arprot = 3'd0;
    s1_arid = 4'hA; s1_araddr = 32'h0040_0000; s1_arlen = 4'd7; s1_arsize = 3'd2;
    s1_arburst = 2'b01; s1_arlock = 2'b00; s1_arcache = 4'h3; s1_arprot = 3'd4;
    s0_arvalid = 1'b0; s1_arvalid = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    m_rid = 4'h5; m_rdata = '0; m_rresp = 2'b01;

    // reset, single s0 read, tie after reset, s1 arready stall, rready back-pressure
    table_q.push_back(mk(1, 0, 7'b0000000, 32'h0,         2'b00, 6'b000000));
    table_q.push_back(mk(0, 0, 7'b0001000, 32'h0,         2'b00, 6'b000000));
    table_q.push_back(mk(0, 0, 7'b1010000, 32'h0,         2'b00, 6'b000000));
    table_q.push_back(mk(0, 0, 7'b1010000, 32'h0,         2'b01, 6'b101000));
    table_q.push_back(mk(0, 0, 7'b0001110, 32'h1234_5678, 2'b01, 6'b010010));
    table_q.push_back(mk(0, 0, 7'b0000000, 32'h0,         2'b00, 6'b000000));
    table_q.push_back(mk(1, 0, 7'b1100000, 32'h0,         2'b00, 6'b000000));
    table_q.push_back(mk(0, 0, 7'b1110000, 32'h0,         2'b00, 6'b000000));
    table_q.push_back(mk(0, 0, 7'b1110000, 32'h0,         2'b01, 6'b101000));
    table_q.push_back(mk(0, 0, 7'b0111010, 32'hA000_0001, 2'b01, 6'b010010));
    table_q.push_back(mk(0, 0, 7'b0111110, 32'hA000_0002, 2'b01, 6'b010010));
    table_q.push_back(mk(0, 0, 7'b0100000, 32'h0,         2'b00, 6'b000000));
    table_q.push_back(mk(0, 0, 7'b0100000, 32'h0,         2'b10, 6'b100000));
    table_q.push_back(mk(0, 0, 7'b0110000, 32'h0,         2'b10, 6'b100100));
    table_q.push_back(mk(0, 0, 7'b0001110, 32'hB000_0001, 2'b10, 6'b000001));
    table_q.push_back(mk(0, 0, 7'b0001101, 32'hB000_0002, 2'b10, 6'b010001));
    table_q.push_back(mk(0, 0, 7'b0000000, 32'h0,         2'b00, 6'b000000));
    foreach (table_q[i]) apply_vec(table_q[i]);

    // s1 8-beat burst, s0 raises arvalid from beat 2 and waits for rlast
    apply_vec(mk(0, 0, 7'b0110000, 32'h0, 2'b00, 6'b000000));
    apply_vec(mk(0, 0, 7'b0110000, 32'h0, 2'b10, 6'b100100));
    for (int k = 0; k < 8; k++) begin
      apply_vec(mk(0, 0, {(k >= 2), 1'b0, 1'b1, 1'b1, (k == 7), 1'b1, 1'b1},
                   32'hC000_0000 + 32'(k), 2'b10, 6'b010001));
    end
    apply_vec(mk(0, 0, 7'b1000000, 32'h0,         2'b00, 6'b000000));
    apply_vec(mk(0, 0, 7'b1010000, 32'h0,         2'b01, 6'b101000));
    apply_vec(mk(0, 0, 7'b0001110, 32'hD000_0000, 2'b01, 6'b010010));
    apply_vec(mk(0, 0, 7'b0000000, 32'h0,         2'b00, 6'b000000));

    // fixed priority: both ports request continuously, s0 wins four times
    apply_vec(mk(1, 1, 7'b0000000, 32'h0, 2'b00, 6'b000000));
    for (int t = 0; t < 4; t++) begin
      apply_vec(mk(0, 1, 7'b1110000, 32'h0, 2'b00, 6'b000000));
      apply_vec(mk(0, 1, 7'b1110000, 32'h0, 2'b01, 6'b101000));
      apply_vec(mk(0, 1, 7'b1111110, 32'hE000_0000 + 32'(t), 2'b01, 6'b010010));
    end
    apply_vec(mk(0, 1, 7'b0110000, 32'h0,         2'b00, 6'b000000));
    apply_vec(mk(0, 1, 7'b0110000, 32'h0,         2'b10, 6'b100100));
    apply_vec(mk(0, 1, 7'b0001101, 32'hF000_0000, 2'b10, 6'b010001));

    // m_arready low for 5 ADDR cycles; s0 drops arvalid partway, grant must hold
    apply_vec(mk(1, 0, 7'b0000000, 32'h0, 2'b00, 6'b000000));
    apply_vec(mk(0, 0, 7'b1000000, 32'h0, 2'b00, 6'b000000));
    for (int i = 0; i < 5; i++) begin
      apply_vec(mk(0, 0, {(i < 3), 6'b000000}, 32'h0, 2'b01, 6'b100000));
    end
    apply_vec(mk(0, 0, 7'b0010000, 32'h0,         2'b01, 6'b101000));
    apply_vec(mk(0, 0, 7'b0001110, 32'h55AA_55AA, 2'b01, 6'b010010));
    apply_vec(mk(0, 0, 7'b0000000, 32'h0,         2'b00, 6'b000000));

    // reset at beat 3 of a 4-beat s0 burst, then a fresh s1 request
    s0_arlen = 4'd3;
    apply_vec(mk(0, 0, 7'b1010000, 32'h0, 2'b00, 6'b000000));
    apply_vec(mk(0, 0, 7'b1010000, 32'h0, 2'b01, 6'b101000));
    for (int k = 0; k < 2; k++) begin
      apply_vec(mk(0, 0, 7'b0001010, 32'h0000_0070 + 32'(k), 2'b01, 6'b010010));
    end
    apply_vec(mk(1, 0, 7'b0001010, 32'h0000_0072, 2'b00, 6'b000000));
    apply_vec(mk(0, 0, 7'b0100000, 32'h0,         2'b00, 6'b000000));
    apply_vec(mk(0, 0, 7'b0110000, 32'h0,         2'b10, 6'b100100));
    apply_vec(mk(0, 0, 7'b0001101, 32'h0000_0099, 2'b10, 6'b010001));
    apply_vec(mk(0, 0, 7'b0000000, 32'h0,         2'b00, 6'b000000));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
